// File: rtl/bundle_word_packer.sv
// Packs a stream of WORD_W-bit words into one NUM_WORDS-slot bundle, slot i at bits [WORD_W*i +: WORD_W].
// Latency: out_valid rises the cycle after the closing word (slot NUM_WORDS-1 or in_last) is accepted.
// Backpressure: single-buffered; in_ready is low from bundle close until the bundle is handed off.
module bundle_word_packer #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 32,
    parameter int CNT_W     = 6,
    parameter int BCNT_W    = 16
) (
    input  logic                        clk_main_200mhz,
    input  logic                        reset,
    input  logic [WORD_W-1:0]           in_word,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_bundle,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            out_word_count,
    output logic                        out_short,
    output logic [BCNT_W-1:0]           bundle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_WORDS - 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] wr_idx;
    logic             accept;
    logic             close_now;

    // Handshake strobes are decoded purely from the state register so no input reaches in_ready.
    assign in_ready       = (state == FILL);
    assign out_valid      = (state == HOLD);
    assign out_word_count = wr_idx;
    assign accept         = in_valid && in_ready;
    assign close_now      = (wr_idx == LAST_IDX) || in_last;

    // Fill slots in order, freeze the bundle when it closes, clear it again on handoff.
    always_ff @(posedge clk_main_200mhz or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wr_idx       <= '0;
            out_bundle   <= '0;
            out_short    <= 1'b0;
            bundle_count <= '0;
        end else begin
            case (state)
                IDLE: state <= FILL;
                FILL: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            if (wr_idx == CNT_W'(i)) begin
                                out_bundle[i*WORD_W +: WORD_W] <= in_word;
                            end
                        end
                        // Counter never rolls over: FILL is left once the final slot is written.
                        wr_idx <= wr_idx + 1'b1;
                        if (close_now) begin
                            state     <= HOLD;
                            out_short <= in_last && (wr_idx != LAST_IDX);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state      <= FILL;
                        out_bundle <= '0;
                        wr_idx     <= '0;
                        out_short  <= 1'b0;
                        if (bundle_count != BCNT_MAX) begin
                            bundle_count <= bundle_count + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bundle_word_packer.sv
// Testbench for bundle_word_packer: directed sequence with randomized data, gaps and lengths.
// Expected bundles are rebuilt from a queue of accepted words; bundle counts from a plain integer.
// A second instance with BCNT_W=2 shares the stimulus to exercise counter saturation.
module tb_bundle_word_packer;

    localparam int W  = 32;
    localparam int N  = 32;
    localparam int CW = 6;

    logic            clk;
    logic            reset;
    logic [W-1:0]    in_word;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [W*N-1:0]  out_bundle;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_word_count;
    logic            out_short;
    logic [15:0]     bundle_count;

    logic            s_in_ready;
    logic [W*N-1:0]  s_out_bundle;
    logic            s_out_valid;
    logic [CW-1:0]   s_out_word_count;
    logic            s_out_short;
    logic [1:0]      s_bundle_count;

    int vectors;
    int miscompares;
    int exp_bcnt;
    logic [W-1:0] q[$];
    logic q_last;

    bundle_word_packer #(.WORD_W(W), .NUM_WORDS(N), .CNT_W(CW), .BCNT_W(16)) dut (
        .clk_main_200mhz(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_bundle(out_bundle), .out_valid(out_valid),
        .out_ready(out_ready), .out_word_count(out_word_count), .out_short(out_short),
        .bundle_count(bundle_count)
    );

    bundle_word_packer #(.WORD_W(W), .NUM_WORDS(N), .CNT_W(CW), .BCNT_W(2)) dut_sat (
        .clk_main_200mhz(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
        .in_last(in_last), .in_ready(s_in_ready), .out_bundle(s_out_bundle), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_word_count(s_out_word_count), .out_short(s_out_short),
        .bundle_count(s_bundle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bundle: accepted words in order, unused slots zero.
    task automatic chk_bundle(input string tag);
        logic [W-1:0] e;
        for (int i = 0; i < N; i++) begin
            e = (i < q.size()) ? q[i] : '0;
            chk(tag, 64'(out_bundle[i*W +: W]), 64'(e));
        end
    endtask

    task automatic chk_counts(input string tag);
        int e16;
        int e2;
        e16 = (exp_bcnt > 65535) ? 65535 : exp_bcnt;
        e2  = (exp_bcnt > 3) ? 3 : exp_bcnt;
        chk({tag, "_bcnt"}, 64'(bundle_count), 64'(e16));
        chk({tag, "_bcnt_sat"}, 64'(s_bundle_count), 64'(e2));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_bundle_nz"}, 64'(|out_bundle), 64'd0);
        chk({tag, "_wcnt"}, 64'(out_word_count), 64'd0);
        chk({tag, "_short"}, 64'(out_short), 64'd0);
        chk({tag, "_bcnt"}, 64'(bundle_count), 64'd0);
        chk({tag, "_bcnt_sat"}, 64'(s_bundle_count), 64'd0);
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) chk("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // Offer one word and wait until it is accepted.
    task automatic send_word(input logic [W-1:0] w, input logic last, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid  = 1'b0;
            in_last   = 1'($urandom);
            in_word   = $urandom;
            out_ready = 1'($urandom);
            step();
        end
        in_word   = w;
        in_valid  = 1'b1;
        in_last   = last;
        out_ready = 1'($urandom);
        wait_ready();
        chk("pre_close_valid", 64'(out_valid), 64'd0);
        step();
        q.push_back(w);
        q_last = last;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // n words (early: in_last on the final one); gap<0 means random 0..2 idle cycles per word.
    task automatic send_bundle(input string tag, input int n, input bit early, input bit rnd,
                               input logic [W-1:0] base, input int gap, input int hold);
        logic [W-1:0] w;
        int g;
        q.delete();
        for (int i = 0; i < n; i++) begin
            w = rnd ? W'($urandom) : base + W'(i);
            g = (i == 0) ? 0 : ((gap < 0) ? $urandom_range(0, 2) : gap);
            send_word(w, early && (i == n - 1), g);
        end
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_wcnt"}, 64'(out_word_count), 64'(q.size()));
        chk({tag, "_short"}, 64'(out_short), 64'(q_last && (q.size() < N)));
        chk_bundle({tag, "_slot"});
        for (int k = 0; k < hold; k++) begin
            in_valid  = 1'b1;
            in_word   = $urandom;
            in_last   = 1'($urandom);
            out_ready = 1'b0;
            step();
            chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_wcnt"}, 64'(out_word_count), 64'(q.size()));
            chk_bundle({tag, "_hold_slot"});
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        exp_bcnt++;
        out_ready = 1'b0;
        chk({tag, "_ho_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_ho_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_ho_bundle_nz"}, 64'(|out_bundle), 64'd0);
        chk({tag, "_ho_wcnt"}, 64'(out_word_count), 64'd0);
        chk({tag, "_ho_short"}, 64'(out_short), 64'd0);
        chk_counts({tag, "_ho"});
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        exp_bcnt    = 0;
        q_last      = 1'b0;
        reset       = 1'b1;
        in_word     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b0;

        // Reset held for three cycles, then release.
        repeat (3) step();
        chk_all_zero("in_reset");
        reset = 1'b0;
        chk_all_zero("post_reset");
        step();
        chk("idle_to_fill_ready", 64'(in_ready), 64'd1);

        // Full bundle 0..31, back-to-back, immediate handoff.
        send_bundle("full", N, 1'b0, 1'b0, 32'h0, 0, 0);
        // Early last after three words.
        send_bundle("early3", 3, 1'b1, 1'b0, 32'hA0, 0, 0);
        // Backpressure: ten cycles of HOLD with traffic on the input.
        send_bundle("bp", N, 1'b0, 1'b1, 32'h0, 0, 10);
        // Gapped input, valid toggling every cycle.
        send_bundle("gap", N, 1'b0, 1'b0, 32'h0, 1, 0);
        // in_last on the final slot is not a short bundle.
        send_bundle("last31", N, 1'b1, 1'b1, 32'h0, 0, 2);
        // Single-word bundle.
        send_bundle("one", 1, 1'b1, 1'b1, 32'h0, 0, 0);

        // Reset after 10 accepted words discards the partial bundle.
        q.delete();
        for (int i = 0; i < 10; i++) send_word(W'($urandom), 1'b0, 0);
        chk("midfill_wcnt", 64'(out_word_count), 64'd10);
        #2;
        reset = 1'b1;
        #1;
        exp_bcnt = 0;
        chk_all_zero("midfill_reset");
        step();
        reset = 1'b0;
        chk("rel_in_ready", 64'(in_ready), 64'd0);
        send_bundle("after_rst", N, 1'b0, 1'b0, 32'h0, 0, 0);

        // Random lengths, gaps and hold times; five handoffs push the 2-bit counter to saturation.
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, N);
            send_bundle("rand", n, (n < N) ? 1'b1 : 1'($urandom), 1'b1, 32'h0, -1,
                        $urandom_range(0, 3));
        end
        chk("final_bcnt", 64'(bundle_count), 64'd6);
        chk("final_bcnt_sat", 64'(s_bundle_count), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bundle_word_packer.md
Name: bundle_word_packer

Overview:
- Opposite direction of the top-level bundle expansion.
- Accepts a stream of 32-bit result words over a valid/ready handshake and packs them into one 1024-bit bundle; word i lands in bits [32*i+31:32*i].
- Presents the completed bundle on a valid/ready output toward the external output bundle port.
- Single-buffered; supports early termination with zero fill.

Parameters:
- WORD_W, 32, width of one input word.
- NUM_WORDS, 32, words per bundle (>=2).
- CNT_W, 6, width of word counters; must hold NUM_WORDS.
- BCNT_W, 16, width of the completed-bundle counter.

Ports:
- clk_main_200mhz  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_word  input  WORD_W  incoming result word.
- in_valid  input  1  in_word valid.
- in_last  input  1  with in_valid: this word closes the bundle early.
- in_ready  output  1  packer accepts a word this cycle.
- out_bundle  output  WORD_W*NUM_WORDS  packed bundle.
- out_valid  output  1  out_bundle complete and stable.
- out_ready  input  1  downstream takes bundle.
- out_word_count  output  CNT_W  words actually written into out_bundle (1..NUM_WORDS).
- out_short  output  1  bundle was closed by in_last before NUM_WORDS words.
- bundle_count  output  BCNT_W  bundles handed off since reset, saturating.

Behaviour:
- State machine IDLE, FILL, HOLD; reset forces IDLE.
- Reset values: in_ready=0, out_valid=0, out_bundle=0, out_word_count=0, out_short=0, bundle_count=0; internal write index=0.
- IDLE -> FILL unconditionally on the next clock edge.
- in_ready = (state==FILL), decoded from the state register only; no combinational path from any input.
- Accept: in_valid && in_ready.
  - On accept, in_word is written at slot wr_idx; wr_idx and out_word_count increment.
  - Non-written slots hold 0.
- FILL -> HOLD when the accepted word is at wr_idx==NUM_WORDS-1, or in_last=1 on the accepted word (whichever comes first).
  - out_short=1 only if in_last closed the bundle with wr_idx<NUM_WORDS-1.
  - in_last on slot NUM_WORDS-1 gives out_short=0.
- Latency: out_valid rises the cycle after the closing word is accepted. Minimum bundle period is NUM_WORDS+1 cycles for a full bundle, with continuous in_valid and immediate out_ready.
- HOLD:
  - out_valid=1; out_bundle, out_word_count and out_short are held stable.
  - in_ready=0; in_valid is ignored.
- Handoff: out_valid && out_ready moves HOLD -> FILL on that edge. Next cycle:
  - out_valid=0, in_ready=1;
  - out_bundle cleared to 0, wr_idx=0, out_word_count=0, out_short=0;
  - bundle_count increments, saturating at 2^BCNT_W-1.
- out_ready while not in HOLD is ignored.
- in_last without in_valid is ignored.
- Reset asserted mid-fill or mid-hold:
  - immediate (asynchronous) return to all reset values;
  - the partial bundle is discarded and not counted.
- No overflow is possible: in_ready drops after the final slot is written.
- Widths: wr_idx wraps only by explicit clear on handoff; never by arithmetic rollover.

Test Plan:
- Reset then idle: reset high 3 cycles, release -> in_ready=0 first cycle, 1 the next; all outputs 0.
- Full bundle: send words 0x00000000..0x0000001F back-to-back, out_ready=1 -> out_valid high exactly 1 cycle after word 31 accepted; out_bundle[31:0]=0x0, out_bundle[1023:992]=0x1F; out_word_count=32, out_short=0; bundle_count=1.
- Early last: words 0xA0,0xA1,0xA2 with in_last on 0xA2 -> out_word_count=3, out_short=1, bits [95:0]=0x000000A2_000000A1_000000A0, bits [1023:96]=0.
- Backpressure: full bundle then out_ready=0 for 10 cycles with in_valid=1 and changing data -> out_bundle unchanged, in_ready=0 throughout; out_ready=1 -> handoff, next bundle starts cleanly with slot 0.
- Gapped input: in_valid toggling 1/0 over 64 cycles for 32 words -> bundle identical to the back-to-back case.
- Reset mid-fill: reset after 10 words accepted -> outputs zero; a subsequent full bundle is correct and bundle_count=1.
- Saturation (BCNT_W=2): 5 handoffs -> bundle_count=3.
